// File: rtl/jtframe_lfbuf_obj.sv
// Line-based 16x16 object renderer feeding the line buffer's core-side write port.
// Define JTFRAME_LFBUF_OBJ_CLR_EN to clear the whole line before objects are drawn.
module jtframe_lfbuf_obj #(
  parameter int DW   = 16,
  parameter int VW   = 8,
  parameter int HW   = 9,
  parameter int OBJW = 7,
  parameter int CW   = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ln_hs,
  input  logic [VW-1:0]   ln_v,
  output logic [HW-1:0]   ln_addr,
  output logic [DW-1:0]   ln_data,
  output logic            ln_we,
  output logic            ln_done,
  output logic [OBJW+1:0] obj_addr,
  input  logic [15:0]     obj_data,
  output logic            rom_cs,
  output logic [CW+4:0]   rom_addr,
  input  logic            rom_ok,
  input  logic [31:0]     rom_data,
  output logic            busy,
  output logic [3:0]      dbg_state
);

  typedef enum logic [3:0] {
    IDLE, CLR, RD0, RD1, RD2, RD3, CHK, FETCH, DRAW, NEXT, DONE
  } state_t;

  state_t          state;
  logic            hs_l;
  logic [VW-1:0]   vline;
  logic [OBJW-1:0] idx;
  logic [VW-1:0]   y;
  logic [HW-1:0]   x;
  logic [CW-1:0]   code;
  logic [3:0]      pal;
  logic            hflip;
  logic [3:0]      row;
  logic            half_k;
  logic [2:0]      n;
  logic [31:0]     pix;
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
  logic [HW-1:0]   clr_cnt;
`endif

  logic            hs_rise;
  logic [VW-1:0]   dy;
  logic            visible;
  logic [3:0]      row_n;
  logic [2:0]      sel;
  logic [31:0]     pix_sh;
  logic [3:0]      cur_pix;
  logic            unused_bits;

  assign dbg_state   = state;
  assign hs_rise     = ln_hs & ~hs_l;
  // In CHK, obj_data already holds word 3 of the current entry
  assign dy          = vline - y;
  assign visible     = obj_data[15] && (dy < VW'(16));
  assign row_n       = obj_data[5] ? ~dy[3:0] : dy[3:0];
  assign sel         = hflip ? ~n : n;
  assign pix_sh      = pix << {sel, 2'b00};
  assign cur_pix     = pix_sh[31:28];
  assign unused_bits = ^obj_data;

  // ROM handshake: rom_cs is the request and rom_addr holds steady while it is
  // high; a cycle with rom_cs and rom_ok both high transfers rom_data, and
  // rom_cs drops on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hs_l     <= ln_hs;
      vline    <= '0;
      idx      <= '0;
      y        <= '0;
      x        <= '0;
      code     <= '0;
      pal      <= '0;
      hflip    <= 1'b0;
      row      <= '0;
      half_k   <= 1'b0;
      n        <= '0;
      pix      <= '0;
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
      clr_cnt  <= '0;
`endif
      ln_addr  <= '0;
      ln_data  <= '0;
      ln_we    <= 1'b0;
      ln_done  <= 1'b0;
      obj_addr <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
    end else begin
      hs_l    <= ln_hs;
      ln_we   <= 1'b0;
      ln_done <= 1'b0;
      if (hs_rise) begin
        // A new request always wins; a line that just finished still reports done
        if (state == DONE) ln_done <= 1'b1;
        vline  <= ln_v;
        idx    <= '1;
        busy   <= 1'b1;
        rom_cs <= 1'b0;
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
        state   <= CLR;
        clr_cnt <= '0;
`else
        state    <= RD0;
        obj_addr <= {{OBJW{1'b1}}, 2'd0};
`endif
      end else begin
        case (state)
          IDLE: ;
          CLR: begin
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
            ln_we   <= 1'b1;
            ln_addr <= clr_cnt;
            ln_data <= '0;
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
              state    <= RD0;
              obj_addr <= {idx, 2'd0};
            end
`else
            state <= IDLE;
`endif
          end
          RD0: begin
            obj_addr <= {idx, 2'd1};
            state    <= RD1;
          end
          RD1: begin
            y        <= obj_data[VW-1:0];
            obj_addr <= {idx, 2'd2};
            state    <= RD2;
          end
          RD2: begin
            x        <= obj_data[HW-1:0];
            obj_addr <= {idx, 2'd3};
            state    <= RD3;
          end
          RD3: begin
            code  <= obj_data[CW-1:0];
            state <= CHK;
          end
          CHK: begin
            pal    <= obj_data[3:0];
            hflip  <= obj_data[4];
            row    <= row_n;
            half_k <= 1'b0;
            if (visible) begin
              rom_cs   <= 1'b1;
              rom_addr <= {code, row_n, obj_data[4]};
              state    <= FETCH;
            end else begin
              state <= NEXT;
            end
          end
          FETCH: begin
            if (rom_ok) begin
              pix    <= rom_data;
              rom_cs <= 1'b0;
              n      <= '0;
              state  <= DRAW;
            end
          end
          DRAW: begin
            ln_we   <= cur_pix != 4'd0;
            ln_addr <= x + HW'({half_k, n});
            ln_data <= DW'({pal, cur_pix});
            n       <= n + 1'b1;
            if (n == 3'd7) begin
              if (!half_k) begin
                half_k   <= 1'b1;
                rom_cs   <= 1'b1;
                rom_addr <= {code, row, ~hflip};
                state    <= FETCH;
              end else begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            if (idx == '0) begin
              state <= DONE;
            end else begin
              idx      <= idx - 1'b1;
              obj_addr <= {idx - 1'b1, 2'd0};
              state    <= RD0;
            end
          end
          DONE: begin
            ln_done <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_lfbuf_obj.sv
// Bench for jtframe_lfbuf_obj: object table RAM, ROM with random latency and a
// scoreboard of expected line-buffer writes and ROM requests.
module tb_jtframe_lfbuf_obj;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ln_hs = 1'b0;
  logic [7:0]  ln_v = '0;
  logic [8:0]  ln_addr;
  logic [15:0] ln_data;
  logic        ln_we, ln_done, rom_cs, busy, rom_ok;
  logic [8:0]  obj_addr;
  logic [15:0] obj_data;
  logic [17:0] rom_addr;
  logic [31:0] rom_data;
  logic [3:0]  dbg_state;

  jtframe_lfbuf_obj dut (
    .clk(clk), .rst(rst), .ln_hs(ln_hs), .ln_v(ln_v),
    .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we), .ln_done(ln_done),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // object table, synchronous read
  logic [15:0] mem [512];
  always @(posedge clk) obj_data <= mem[obj_addr];

  // graphics ROM: same pattern at every address, rom_ok after 0..3 cycles
  logic [31:0] rom_pat = '0;
  int          rom_wait = 0;
  assign rom_data = rom_pat;
  initial rom_ok = 1'b0;
  always @(posedge clk) begin
    rom_ok <= 1'b0;
    if (rom_cs && !rom_ok) begin
      if (rom_wait == 0) begin
        rom_ok   <= 1'b1;
        rom_wait <= $urandom_range(0, 3);
      end else begin
        rom_wait <= rom_wait - 1;
      end
    end
  end

  // scoreboard
  logic [24:0] exp_q [$];
  logic [17:0] rom_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_on = 1'b0;
  int          done_cnt = 0, done_cyc = 0, obj_wr = 0, wr_cnt = 0, rom_cnt = 0;
  logic [8:0]  first_addr, last_addr, first_wr_addr;
  logic [15:0] first_data;
  logic [17:0] rom_seen [2];
  logic [3:0]  pal_buf [512];
  logic        rom_cs_l = 1'b0;
  logic [24:0] e;
  logic [17:0] er;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ln_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sb_on && ln_we) begin
      if (wr_cnt == 0) first_wr_addr = ln_addr;
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_extra", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("wr", {ln_addr, ln_data}, e);
      end
      if (ln_data[3:0] != 4'd0) begin
        if (obj_wr == 0) begin
          first_addr = ln_addr;
          first_data = ln_data;
        end
        last_addr = ln_addr;
        pal_buf[ln_addr] = ln_data[7:4];
        obj_wr++;
      end
    end
    if (sb_on && rom_cs && !rom_cs_l) begin
      if (rom_cnt < 2) rom_seen[rom_cnt] = rom_addr;
      rom_cnt++;
      if (rom_q.size() == 0) check("rom_extra", rom_q.size(), 1);
      else begin
        er = rom_q.pop_front();
        check("rom_addr", rom_addr, er);
      end
    end
    rom_cs_l = rom_cs;
  end

  // reference model of one line
  task automatic model_line(input logic [7:0] v);
    logic [7:0]  r;
    logic [3:0]  r4, p;
    logic [15:0] w3;
    logic [2:0]  nb;
    logic [8:0]  a;
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
    for (int a2 = 0; a2 < 512; a2++) exp_q.push_back({9'(a2), 16'h0000});
`endif
    for (int i = 127; i >= 0; i--) begin
      w3 = mem[4*i+3];
      r  = v - mem[4*i][7:0];
      if (w3[15] && r < 8'd16) begin
        r4 = w3[5] ? 4'(15 - r) : r[3:0];
        for (int k = 0; k < 2; k++) begin
          rom_q.push_back({mem[4*i+2][12:0], r4, 1'(k) ^ w3[4]});
          for (int n = 0; n < 8; n++) begin
            nb = w3[4] ? 3'(7 - n) : 3'(n);
            p  = rom_pat[31-4*nb -: 4];
            a  = 9'(mem[4*i+1][8:0] + 8*k + n);
            if (p != 4'd0) exp_q.push_back({a, 8'h00, w3[3:0], p});
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic clear_objs();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  endtask

  task automatic set_obj(input int i, input logic [15:0] y, input logic [15:0] x,
                         input logic [15:0] code, input logic [15:0] w3);
    mem[4*i]   = y;
    mem[4*i+1] = x;
    mem[4*i+2] = code;
    mem[4*i+3] = w3;
  endtask

  task automatic sb_reset();
    exp_q.delete();
    rom_q.delete();
    obj_wr = 0; wr_cnt = 0; rom_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 512; i++) pal_buf[i] = 4'd0;
    sb_on = 1'b1;
  endtask

  task automatic pulse_hs(input logic [7:0] v, output int t0);
    @(posedge clk);
    #1 ln_v = v; ln_hs = 1'b1; t0 = cyc;
    @(posedge clk);
    #1 ln_hs = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt > 0, 1);
    repeat (6) @(posedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_wr_left"}, exp_q.size(), 0);
    check({tag, "_rom_left"}, rom_q.size(), 0);
  endtask

  task automatic run_line(input string tag, input logic [7:0] v, output int lat);
    int t0;
    sb_reset();
    model_line(v);
    pulse_hs(v, t0);
    wait_done(tag);
    lat = done_cyc - t0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_ctl"}, {ln_we, rom_cs, ln_done, busy}, 4'd0);
    check({tag, "_addr"}, {ln_addr, obj_addr}, 18'd0);
    check({tag, "_rom"}, rom_addr, 18'd0);
    check({tag, "_data"}, ln_data, 16'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, t0, n, clr;
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
    clr = 512;
`else
    clr = 0;
`endif
    clear_objs();

    // reset with ln_hs toggling
    repeat (3) begin
      @(posedge clk);
      #1 ln_hs = ~ln_hs;
      @(negedge clk);
      check_idle_outs("reset");
    end
    ln_hs = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_reset_busy", {busy, ln_we, rom_cs}, 3'd0);

    // single object
    set_obj(0, 10, 20, 5, 16'h8003);
    rom_pat = 32'h1111_1111;
    run_line("single", 8'd12, lat);
    check("single_rom0", rom_seen[0], {13'd5, 4'd2, 1'b0});
    check("single_rom1", rom_seen[1], {13'd5, 4'd2, 1'b1});
    check("single_nwr", obj_wr, 16);
    check("single_first_addr", first_addr, 9'd20);
    check("single_last_addr", last_addr, 9'd35);
    check("single_data", first_data, 16'h0031);

    // nothing visible
    clear_objs();
    run_line("empty", 8'd100, lat);
    check("empty_rom", rom_cnt, 0);
    check("empty_wr", wr_cnt, clr);
    check("empty_lat", (lat >= clr + 640) && (lat <= clr + 768 + 16), 1);

    // wrap-around with horizontal flip
    set_obj(0, 50, 505, 9, 16'h8012);
    rom_pat = 32'h1234_5678;
    run_line("wrap", 8'd53, lat);
    check("wrap_rom0", rom_seen[0], {13'd9, 4'd3, 1'b1});
    check("wrap_rom1", rom_seen[1], {13'd9, 4'd3, 1'b0});
    check("wrap_first_addr", first_addr, 9'd505);
    check("wrap_first_data", first_data, 16'h0028);
    check("wrap_last_addr", last_addr, 9'd8);
    check("wrap_nwr", obj_wr, 16);

    // vertical flip and transparent pixels
    clear_objs();
    set_obj(0, 50, 200, 9, 16'h8021);
    rom_pat = 32'h1020_3040;
    run_line("vflip", 8'd53, lat);
    check("vflip_rom0", rom_seen[0], {13'd9, 4'd12, 1'b0});
    check("vflip_nwr", obj_wr, 8);
    check("vflip_first_data", first_data, 16'h0011);

    // priority: object 0 drawn last
    clear_objs();
    set_obj(0, 10, 20, 5, 16'h8001);
    set_obj(1, 10, 20, 6, 16'h8002);
    rom_pat = 32'h1111_1111;
    run_line("prio", 8'd12, lat);
    check("prio_nwr", obj_wr, 32);
    check("prio_first_pal", first_data[7:4], 4'd2);
    check("prio_pal20", pal_buf[20], 4'd1);
    check("prio_pal35", pal_buf[35], 4'd1);

    // abort during the first DRAW
    clear_objs();
    set_obj(0, 40, 100, 7, 16'h8003);
    sb_reset();
    model_line(8'd40);
    pulse_hs(8'd40, t0);
    n = 0;
    while (obj_wr == 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("abort_draw_seen", obj_wr > 0, 1);
    check("abort_no_done", done_cnt, 0);
    #1 ln_v = 8'd40; ln_hs = 1'b1;
    @(posedge clk);
    #1 ln_hs = 1'b0;
    exp_q.delete();
    rom_q.delete();
    model_line(8'd40);
    obj_wr = 0; wr_cnt = 0; rom_cnt = 0;
    @(negedge clk);
    check("abort_drop", {ln_we, rom_cs}, 2'd0);
    wait_done("abort");
    check("abort_nwr", obj_wr, 16);
`ifdef JTFRAME_LFBUF_OBJ_CLR_EN
    check("abort_clr_start", first_wr_addr, 9'd0);
`endif

    // reset in the middle of a line
    sb_on = 1'b0;
    clear_objs();
    set_obj(0, 60, 0, 1, 16'h8000);
    pulse_hs(8'd60, t0);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outs("midrst");
    done_cnt = 0;
    repeat (2000) @(posedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", {busy, rom_cs}, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
